l1_refill_ctrl: RTL and testbench
=================================

Name: l1_refill_ctrl

Overview:
- Memory-side miss handler for the L1 data cache: the initiator toward main memory, where the L1 is the responder to the CPU.
- On a miss it optionally writes back the dirty victim line, then burst-reads the new line one word at a time.
- Returns the assembled line to the cache with a one-cycle ack.
- Sits between the L1 array and the data memory port; at most one memory transaction is outstanding.

Parameters:
- LINE_WORDS, 4, words per cache line (power of two, >=2).
- ADDR_W, 32, byte address width.
- TIMEOUT, 255, max cycles waiting on mem_ready or mem_rvalid before abort (8-bit counter).

Ports:
- clk  in  1  clock.
- reset  in  1  reset; asynchronous, active-high.
- miss_req  in  1  miss request; held high by the cache until miss_ack or miss_err.
- miss_addr  in  ADDR_W  byte address of the missing access.
- victim_dirty  in  1  victim line must be written back first.
- victim_addr  in  ADDR_W  byte address of the victim line.
- victim_data  in  LINE_WORDS*32  victim line; word i is bits [32i+31:32i].
- fill_data  out  LINE_WORDS*32  refilled line, same packing as victim_data.
- miss_ack  out  1  one-cycle pulse; fill_data is valid in that cycle and stays stable until the next accepted request.
- miss_err  out  1  one-cycle pulse on timeout abort.
- busy  out  1  high in every state except IDLE.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read; qualified by mem_req.
- mem_addr  out  ADDR_W  word-aligned byte address.
- mem_wdata  out  32  write data.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rdata  in  32  read data.
- mem_rvalid  in  1  read data valid.

Behaviour:
- Reset values: all outputs 0, fill_data 0, state IDLE, word counter 0, timeout counter 0.
- Reset mid-operation aborts immediately. The partial line is discarded and no ack or err pulse is issued.
- Line base address is the input address with its low log2(LINE_WORDS)+2 bits cleared. Word i is at base + 4*i. The word counter wraps to 0 after LINE_WORDS-1.
- IDLE: when miss_req=1, register miss_addr, victim_addr, victim_data and victim_dirty. Go to WB if victim_dirty, else RD_REQ. First mem_req appears one cycle after capture.
- WB: mem_req=1, mem_we=1, mem_addr=victim base+4*cnt, mem_wdata=victim word cnt.
  - Handshake completes in a cycle with mem_req & mem_ready; cnt increments.
  - After the last word is accepted, cnt=0 and go to RD_REQ.
- RD_REQ: mem_req=1, mem_we=0, mem_addr=miss base+4*cnt.
  - On mem_ready, drop mem_req the next cycle and go to RD_WAIT.
  - If mem_rvalid is also high in the accept cycle, take the word directly and skip RD_WAIT.
- RD_WAIT: mem_req=0. On mem_rvalid, write mem_rdata into fill word cnt and increment cnt. Go to RD_REQ, or to DONE after the last word.
- DONE: miss_ack=1 for exactly one cycle, then IDLE.
  - miss_req still high in the first IDLE cycle is treated as a new request; the cache must drop it on ack.
- Addr, we and wdata stay stable while mem_req=1 and mem_ready=0.
- mem_rvalid outside RD_REQ/RD_WAIT is ignored. miss_req while busy is ignored. Input changes after capture have no effect.
- Timeout: counter clears on each state change and on each handshake, and increments every other non-IDLE cycle. On reaching TIMEOUT: miss_err=1 for one cycle, mem_req=0, go to IDLE, fill_data unchanged.
- Best case clean miss with mem_ready=1 and mem_rvalid in the accept cycle: ack LINE_WORDS+2 cycles after capture.

Test Plan:
- Clean miss: miss_addr=0x0000_1234, victim_dirty=0, memory returns addr^0xA5A5_0000 with ready=1 and same-cycle rvalid. Required: reads at 0x1230, 0x1234, 0x1238, 0x123C in order; fill_data words equal 0xA5A5_1230..0xA5A5_123C; single miss_ack; busy low the cycle after.
- Dirty miss: victim_addr=0x0000_2000, victim_data words 0x11,0x22,0x33,0x44; miss_addr=0x3008. Required: four writes to 0x2000–0x200C with data 0x11–0x44, then four reads at 0x3000–0x300C.
- Backpressure: mem_ready low 3 cycles per request, rvalid 2 cycles after accept. Required: mem_addr and mem_wdata stable while stalled; correct line; no duplicate requests.
- Timeout: mem_ready stuck 0 on the first read. Required: miss_err pulse after 255 stall cycles, mem_req=0, busy=0, no miss_ack.
- Reset mid-read after word 1 (reset asserted asynchronously between clock edges). Required: all outputs 0 immediately; a subsequent miss to 0x4000 completes correctly starting at word 0.
- Stray inputs: mem_rvalid pulsed in IDLE, and miss_req toggled while busy. Required: no state change and no extra transaction; exactly one ack per accepted miss.

Source files
------------

// File: rtl/l1_refill_ctrl.sv
// L1 data-cache miss handler: writes back a dirty victim line, then burst-reads
// the missing line word by word and returns it with a one-cycle ack.
module l1_refill_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     miss_req,
  input  logic [ADDR_W-1:0]        miss_addr,
  input  logic                     victim_dirty,
  input  logic [ADDR_W-1:0]        victim_addr,
  input  logic [LINE_WORDS*32-1:0] victim_data,
  output logic [LINE_WORDS*32-1:0] fill_data,
  output logic                     miss_ack,
  output logic                     miss_err,
  output logic                     busy,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ready,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_rvalid
);

  localparam int CW  = $clog2(LINE_WORDS);
  localparam int OFF = CW + 2;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((1 << OFF) - 1);
  localparam logic [CW-1:0]     LAST      = CW'(LINE_WORDS - 1);
  localparam logic [7:0]        TLIM      = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WB, RD_REQ, RD_WAIT, DONE} state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [CW-1:0]            cnt_inc;
  logic [7:0]               tcnt;
  logic [ADDR_W-1:0]        miss_base;
  logic [ADDR_W-1:0]        victim_base;
  logic [LINE_WORDS*32-1:0] victim_line;
  logic [LINE_WORDS*32-1:0] line_buf;
  logic [LINE_WORDS*32-1:0] line_next;
  logic                     stall_now;
  logic                     abort;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [CW-1:0]     idx);
    return base + ADDR_W'({idx, 2'b00});
  endfunction

  assign cnt_inc = cnt + 1'b1;

  // A waiting cycle is any busy cycle that is neither a handshake nor a state change.
  assign stall_now = ((state == WB || state == RD_REQ) && !mem_ready) ||
                     (state == RD_WAIT && !mem_rvalid);
  assign abort     = stall_now && (tcnt == TLIM);

  always_comb begin
    line_next = line_buf;
    line_next[32*int'(cnt) +: 32] = mem_rdata;
  end

  // The line is assembled in line_buf and only copied to fill_data on completion,
  // so an aborted refill leaves the previously returned line untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      tcnt        <= '0;
      miss_base   <= '0;
      victim_base <= '0;
      victim_line <= '0;
      line_buf    <= '0;
      fill_data   <= '0;
      miss_ack    <= 1'b0;
      miss_err    <= 1'b0;
      busy        <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      miss_ack <= 1'b0;
      miss_err <= 1'b0;
      tcnt     <= stall_now ? tcnt + 8'd1 : 8'd0;
      if (abort) begin
        state   <= IDLE;
        cnt     <= '0;
        tcnt    <= '0;
        busy    <= 1'b0;
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        miss_err <= 1'b0 | 1'b1;
      end else begin
        unique case (state)
          // The err cycle is already IDLE while the cache still holds miss_req.
          IDLE: begin
            if (miss_req && !miss_err) begin
              miss_base   <= miss_addr & ~LINE_MASK;
              victim_base <= victim_addr & ~LINE_MASK;
              victim_line <= victim_data;
              cnt         <= '0;
              busy        <= 1'b1;
              mem_req     <= 1'b1;
              mem_we      <= victim_dirty;
              mem_addr    <= victim_dirty ? (victim_addr & ~LINE_MASK) : (miss_addr & ~LINE_MASK);
              mem_wdata   <= victim_dirty ? victim_data[31:0] : 32'h0;
              state       <= victim_dirty ? WB : RD_REQ;
            end
          end
          WB: begin
            if (mem_ready) begin
              if (cnt == LAST) begin
                cnt       <= '0;
                mem_we    <= 1'b0;
                mem_wdata <= 32'h0;
                mem_addr  <= miss_base;
                state     <= RD_REQ;
              end else begin
                cnt       <= cnt_inc;
                mem_addr  <= word_addr(victim_base, cnt_inc);
                mem_wdata <= victim_line[32*int'(cnt_inc) +: 32];
              end
            end
          end
          RD_REQ: begin
            if (mem_ready) begin
              if (mem_rvalid) begin
                line_buf <= line_next;
                if (cnt == LAST) begin
                  cnt       <= '0;
                  mem_req   <= 1'b0;
                  fill_data <= line_next;
                  state     <= DONE;
                end else begin
                  cnt      <= cnt_inc;
                  mem_addr <= word_addr(miss_base, cnt_inc);
                end
              end else begin
                mem_req <= 1'b0;
                state   <= RD_WAIT;
              end
            end
          end
          RD_WAIT: begin
            if (mem_rvalid) begin
              line_buf <= line_next;
              if (cnt == LAST) begin
                cnt       <= '0;
                fill_data <= line_next;
                state     <= DONE;
              end else begin
                cnt      <= cnt_inc;
                mem_req  <= 1'b1;
                mem_addr <= word_addr(miss_base, cnt_inc);
                state    <= RD_REQ;
              end
            end
          end
          // First DONE cycle raises the ack, second drops it and returns to IDLE.
          DONE: begin
            if (!miss_ack) begin
              miss_ack <= 1'b1;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Self-checking bench for l1_refill_ctrl: table-driven refills against a memory
// responder with configurable latency, plus timeout, reset and stray-input sequences.
module tb_l1_refill_ctrl;

  logic         clk;
  logic         reset;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         victim_dirty;
  logic [31:0]  victim_addr;
  logic [127:0] victim_data;
  logic [127:0] fill_data;
  logic         miss_ack;
  logic         miss_err;
  logic         busy;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ready;
  logic [31:0]  mem_rdata;
  logic         mem_rvalid;

  l1_refill_ctrl #(.LINE_WORDS(4), .ADDR_W(32), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .miss_req(miss_req), .miss_addr(miss_addr), .victim_dirty(victim_dirty),
    .victim_addr(victim_addr), .victim_data(victim_data),
    .fill_data(fill_data), .miss_ack(miss_ack), .miss_err(miss_err), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
  } op_t;

  typedef struct {
    logic [31:0]  miss_addr;
    logic         dirty;
    logic [31:0]  victim_addr;
    logic [127:0] victim_data;
    int           rdy_lat;
    int           rv_lat;
    logic         toggle;
    logic [31:0]  exp_wb_base;
    logic [31:0]  exp_rd_base;
    logic [127:0] exp_fill;
    int           exp_ack;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   ack_count = 0;
  int   err_count = 0;
  op_t  log_q[$];

  int          rdy_lat = 0;
  int          rv_lat = 0;
  bit          stuck = 0;
  bit          stray_rv = 0;
  int          wait_cnt = 0;
  int          pend_rv = -1;
  logic [31:0] pend_data = '0;
  bit          stall_prev = 0;
  logic [64:0] prev_cmd = '0;

  vec_t vecs[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory responder: drives at the falling edge, logs every handshake and checks
  // that a stalled request holds its command steady.
  always @(negedge clk) begin
    if (reset) begin
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      pend_rv = -1; wait_cnt = 0; stall_prev = 0;
    end else begin
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (pend_rv > 0) begin
        pend_rv--;
        if (pend_rv == 0) begin
          mem_rvalid = 1'b1; mem_rdata = pend_data; pend_rv = -1;
        end
      end
      if (stall_prev && mem_req) checkOutput("stall_hold", {mem_we, mem_addr, mem_wdata}, prev_cmd);
      stall_prev = 0;
      if (mem_req && !stuck && wait_cnt >= rdy_lat) begin
        mem_ready = 1'b1;
        wait_cnt = 0;
        log_q.push_back('{mem_we, mem_addr, mem_wdata});
        if (!mem_we) begin
          if (rv_lat == 0) begin
            mem_rvalid = 1'b1; mem_rdata = mem_addr ^ 32'hA5A5_0000;
          end else begin
            pend_rv = rv_lat; pend_data = mem_addr ^ 32'hA5A5_0000;
          end
        end
      end else if (mem_req) begin
        if (!stuck) wait_cnt++;
        stall_prev = 1;
        prev_cmd = {mem_we, mem_addr, mem_wdata};
      end
      if (stray_rv) begin
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_DEAD;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && miss_ack) ack_count++;
    if (!reset && miss_err) err_count++;
  end

  // Runs one refill from a table entry and checks latency, line, bus trace and ack count.
  task automatic applyStimulus(input vec_t v, input int idx);
    int           ack_at;
    int           acks0;
    int           exp_n;
    logic [127:0] fill_at_ack;
    logic [31:0]  ea;
    logic [64:0]  exp_op;
    logic [64:0]  act_op;
    log_q.delete();
    rdy_lat = v.rdy_lat;
    rv_lat  = v.rv_lat;
    stuck   = 0;
    acks0   = ack_count;
    @(negedge clk);
    miss_addr = v.miss_addr; victim_dirty = v.dirty;
    victim_addr = v.victim_addr; victim_data = v.victim_data; miss_req = 1'b1;
    @(posedge clk);
    ack_at = -1;
    fill_at_ack = '0;
    for (int n = 1; n <= 300 && ack_at < 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        miss_addr = $urandom; victim_addr = $urandom; victim_dirty = ~v.dirty;
        victim_data = {$urandom, $urandom, $urandom, $urandom};
      end
      if (v.toggle && n <= 4) miss_req = (n % 2 == 0);
      if (v.toggle) stray_rv = (n <= 3);
      if (miss_ack) begin
        ack_at = n; fill_at_ack = fill_data; miss_req = 1'b0;
      end
    end
    miss_req = 1'b0;
    stray_rv = 0;
    checkOutput($sformatf("v%0d_ack_latency", idx), ack_at, v.exp_ack);
    checkOutput($sformatf("v%0d_fill_data", idx), fill_at_ack, v.exp_fill);
    @(negedge clk);
    checkOutput($sformatf("v%0d_idle_after_ack", idx), {busy, miss_ack, mem_req}, 3'b000);
    repeat (4) @(negedge clk);
    checkOutput($sformatf("v%0d_ack_count", idx), ack_count - acks0, 1);
    exp_n = v.dirty ? 8 : 4;
    checkOutput($sformatf("v%0d_op_count", idx), log_q.size(), exp_n);
    for (int k = 0; k < exp_n; k++) begin
      if (v.dirty && k < 4) begin
        ea = v.exp_wb_base + 32'(4 * k);
        exp_op = {1'b1, ea, v.victim_data[32*k +: 32]};
      end else begin
        ea = v.exp_rd_base + 32'(4 * (v.dirty ? k - 4 : k));
        exp_op = {1'b0, ea, 32'h0};
      end
      if (k < log_q.size()) act_op = {log_q[k].we, log_q[k].addr, log_q[k].we ? log_q[k].wdata : 32'h0};
      else act_op = '1;
      checkOutput($sformatf("v%0d_op%0d", idx, k), act_op, exp_op);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int           stalls;
    int           acks0;
    bit           got;
    bit           quiet;
    logic [127:0] prev_fill;
    logic [2:0]   err_flags;

    //             miss_addr     dirty victim_addr   victim_data                                  rdy rv tog wb_base       rd_base       exp_fill                                      ack
    vecs[0] = '{32'h0000_1234, 1'b0, 32'h0,        128'h0,                                            0, 0, 1'b0, 32'h0,        32'h0000_1230, 128'hA5A5123C_A5A51238_A5A51234_A5A51230,  6};
    vecs[1] = '{32'h0000_3008, 1'b1, 32'h0000_2000, 128'h00000044_00000033_00000022_00000011,         0, 0, 1'b0, 32'h0000_2000, 32'h0000_3000, 128'hA5A5300C_A5A53008_A5A53004_A5A53000, 10};
    vecs[2] = '{32'h0000_5678, 1'b0, 32'h0,        128'h0,                                            3, 2, 1'b0, 32'h0,        32'h0000_5670, 128'hA5A5567C_A5A55678_A5A55674_A5A55670, 26};
    vecs[3] = '{32'hFFFF_FFF4, 1'b1, 32'h0000_6A3C, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0,         3, 2, 1'b0, 32'h0000_6A30, 32'hFFFF_FFF0, 128'h5A5AFFFC_5A5AFFF8_5A5AFFF4_5A5AFFF0, 42};
    vecs[4] = '{32'h0000_0010, 1'b0, 32'h0,        128'h0,                                            1, 1, 1'b0, 32'h0,        32'h0000_0010, 128'hA5A5001C_A5A50018_A5A50014_A5A50010, 14};
    vecs[5] = '{32'h8000_0003, 1'b0, 32'h0,        128'h0,                                            2, 0, 1'b0, 32'h0,        32'h8000_0000, 128'h25A5000C_25A50008_25A50004_25A50000, 14};
    vecs[6] = '{32'h0000_B004, 1'b1, 32'h0000_A000, 128'h00000004_00000003_00000002_00000001,         0, 0, 1'b1, 32'h0000_A000, 32'h0000_B000, 128'hA5A5B00C_A5A5B008_A5A5B004_A5A5B000, 10};
    vecs[7] = '{32'h0000_4000, 1'b0, 32'h0,        128'h0,                                            0, 0, 1'b0, 32'h0,        32'h0000_4000, 128'hA5A5400C_A5A54008_A5A54004_A5A54000,  6};

    reset = 1'b1; miss_req = 1'b0; miss_addr = '0; victim_dirty = 1'b0;
    victim_addr = '0; victim_data = '0;
    mem_ready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {miss_ack, miss_err, busy, mem_req, mem_we, mem_addr, mem_wdata}, '0);
    checkOutput("reset_fill", fill_data, '0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

    // Timeout: memory never accepts the first read.
    prev_fill = fill_data;
    log_q.delete();
    acks0 = ack_count;
    stuck = 1;
    @(negedge clk);
    miss_addr = 32'h0000_7000; victim_dirty = 1'b0; miss_req = 1'b1;
    @(posedge clk);
    stalls = 0; got = 0; err_flags = '1;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (miss_err) begin
        got = 1; err_flags = {mem_req, busy, miss_ack}; miss_req = 1'b0;
      end else if (mem_req) stalls++;
    end
    miss_req = 1'b0;
    checkOutput("timeout_err_seen", got, 1'b1);
    checkOutput("timeout_stall_cycles", stalls, 255);
    checkOutput("timeout_err_outputs", err_flags, 3'b000);
    checkOutput("timeout_fill_kept", fill_data, prev_fill);
    @(negedge clk);
    checkOutput("timeout_err_one_cycle", {miss_err, busy, mem_req}, 3'b000);
    checkOutput("timeout_no_ack", ack_count - acks0, 0);
    checkOutput("timeout_no_handshake", log_q.size(), 0);
    stuck = 0;

    // Stray read data while idle must not start anything.
    prev_fill = fill_data;
    log_q.delete();
    quiet = 1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      stray_rv = (n < 3);
      if (busy || mem_req || miss_ack || miss_err) quiet = 0;
    end
    stray_rv = 0;
    checkOutput("stray_rv_idle_quiet", quiet, 1'b1);
    checkOutput("stray_rv_idle_nolog", log_q.size(), 0);
    checkOutput("stray_rv_idle_fill", fill_data, prev_fill);

    // miss_req toggling while busy plus stray rvalid during write-back.
    applyStimulus(vecs[6], 6);

    // Asynchronous reset in the middle of the read burst.
    log_q.delete();
    rdy_lat = 0; rv_lat = 2;
    @(negedge clk);
    miss_addr = 32'h0000_9000; victim_dirty = 1'b0; miss_req = 1'b1;
    for (int n = 0; n < 100 && log_q.size() < 2; n++) @(negedge clk);
    checkOutput("midreset_reached_word1", log_q.size() >= 2, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    miss_req = 1'b0;
    #1;
    checkOutput("midreset_outputs", {miss_ack, miss_err, busy, mem_req, mem_we, mem_addr, mem_wdata}, '0);
    checkOutput("midreset_fill", fill_data, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(vecs[7], 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
